audio_envelope: RTL and testbench



---
 rtl/audio_env_pkg.sv | 24 ++
 rtl/pwm_dac.sv | 31 +++
 rtl/audio_envelope.sv | 182 ++++++++++++++++++
 tb/tb_audio_envelope.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_env_pkg.sv
// Shared definitions for the audio envelope block: state encoding,
// default parameter values and the full-scale level helper.
package audio_env_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

  localparam int DEF_LEVEL_W      = 6;
  localparam int DEF_ATTACK_STEP  = 8;
  localparam int DEF_DECAY_STEP   = 1;
  localparam int DEF_SUSTAIN_LVL  = 24;
  localparam int DEF_RELEASE_STEP = 2;

  // Full-scale envelope/PWM value for a given resolution.
  function automatic int level_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_dac.sv
// 1-bit PWM output stage: a free-running counter compared against the
// envelope level, gated by the synchronised tone.
module pwm_dac
  import audio_env_pkg::*;
#(
  parameter int LEVEL_W = DEF_LEVEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tone_s,
  input  logic [LEVEL_W-1:0] level,
  output logic               audio
);

  logic [LEVEL_W-1:0] r_cnt;
  logic               r_audio;

  // Counter wraps MAX->0; output is high for `level` counts out of 2**LEVEL_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_audio <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + LEVEL_W'(1);
      r_audio <= tone_s & (r_cnt < level);
    end
  end

  assign audio = r_audio;

endmodule

// File: rtl/audio_envelope.sv
// ADSR amplitude envelope driving a PWM audio output.
// Build option: define AUDIO_ENV_SUSTAIN_EN for the full ADSR with a
// sustain plateau; without it the envelope is percussive (decay runs to
// zero and the note ends even while gate is still high).
//
// state      | meaning
// IDLE       | silent, level 0, waiting for gate
// ATTACK     | rising by ATTACK_STEP per tick up to MAX
// DECAY      | falling by DECAY_STEP per tick to the floor
// SUSTAIN    | holding SUSTAIN_LVL while gate stays high
// RELEASE    | gate dropped, falling by RELEASE_STEP per tick to 0
module audio_envelope
  import audio_env_pkg::*;
#(
  parameter int LEVEL_W      = DEF_LEVEL_W,
  parameter int ATTACK_STEP  = DEF_ATTACK_STEP,
  parameter int DECAY_STEP   = DEF_DECAY_STEP,
  parameter int SUSTAIN_LVL  = DEF_SUSTAIN_LVL,
  parameter int RELEASE_STEP = DEF_RELEASE_STEP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tone_in,
  input  logic               gate,
  input  logic               tick,
  output logic               audio,
  output logic [LEVEL_W-1:0] level,
  output logic               busy
);

  localparam int MAX = level_max(LEVEL_W);
  localparam logic [LEVEL_W:0] C_MAX = (LEVEL_W+1)'(MAX);
  localparam logic [LEVEL_W:0] C_ATT = (LEVEL_W+1)'(ATTACK_STEP);
  localparam logic [LEVEL_W:0] C_DEC = (LEVEL_W+1)'(DECAY_STEP);
  localparam logic [LEVEL_W:0] C_REL = (LEVEL_W+1)'(RELEASE_STEP);
`ifdef AUDIO_ENV_SUSTAIN_EN
  localparam logic [LEVEL_W:0] C_FLOOR = (LEVEL_W+1)'(SUSTAIN_LVL);
`else
  localparam logic [LEVEL_W:0] C_FLOOR = '0;
`endif

  if (SUSTAIN_LVL < 0 || SUSTAIN_LVL > MAX) begin : g_bad_sustain
    $error("audio_envelope: SUSTAIN_LVL out of range");
  end

  logic               r_sync1;
  logic               r_sync2;
  env_state_e         r_state;
  logic [LEVEL_W-1:0] r_level;
  logic               r_busy;

  logic [LEVEL_W:0]   w_lvl_ext;
  logic [LEVEL_W:0]   w_att_sum;
  logic               w_att_sat;
  logic [LEVEL_W:0]   w_dec_next;
  logic               w_dec_hit;
  logic [LEVEL_W:0]   w_rel_next;
  logic               w_rel_hit;
  logic               w_start;

  // All arithmetic one bit wider so saturation never wraps.
  assign w_lvl_ext  = {1'b0, r_level};
  assign w_att_sum  = w_lvl_ext + C_ATT;
  assign w_att_sat  = (w_att_sum >= C_MAX);
  assign w_dec_next = w_lvl_ext - C_DEC;
  assign w_dec_hit  = (w_lvl_ext <= C_FLOOR + C_DEC);
  assign w_rel_next = w_lvl_ext - C_REL;
  assign w_rel_hit  = (w_lvl_ext <= C_REL);

`ifdef AUDIO_ENV_SUSTAIN_EN
  assign w_start = gate;
`else
  // After a percussive note ends with gate still high, a fresh note
  // needs the gate to be seen low first.
  logic r_rearm;
  assign w_start = gate & ~r_rearm;

  // Arm flag: set when decay finishes, cleared by any low gate.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rearm <= 1'b0;
    end else if (!gate) begin
      r_rearm <= 1'b0;
    end else if (r_state == ST_DECAY && tick && w_dec_hit) begin
      r_rearm <= 1'b1;
    end
  end
`endif

  // Two-flop synchroniser for the tone, which is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= tone_in;
      r_sync2 <= r_sync1;
    end
  end

  // Envelope FSM; gate-driven transitions take priority and suppress the level step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_level <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_ATTACK;
            r_busy  <= 1'b1;
          end
        end
        ST_ATTACK: begin
          if (!gate) begin
            r_state <= ST_RELEASE;
          end else if (tick) begin
            if (w_att_sat) begin
              r_level <= C_MAX[LEVEL_W-1:0];
              r_state <= ST_DECAY;
            end else begin
              r_level <= w_att_sum[LEVEL_W-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (!gate) begin
            r_state <= ST_RELEASE;
          end else if (tick) begin
            if (w_dec_hit) begin
              r_level <= C_FLOOR[LEVEL_W-1:0];
`ifdef AUDIO_ENV_SUSTAIN_EN
              r_state <= ST_SUSTAIN;
`else
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
`endif
            end else begin
              r_level <= w_dec_next[LEVEL_W-1:0];
            end
          end
        end
        ST_SUSTAIN: begin
          if (!gate) begin
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (gate) begin
            r_state <= ST_ATTACK;
          end else if (tick) begin
            if (w_rel_hit) begin
              r_level <= '0;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_level <= w_rel_next[LEVEL_W-1:0];
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_level <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  pwm_dac #(.LEVEL_W(LEVEL_W)) u_pwm_dac (
    .clk   (clk),
    .rst   (rst),
    .tone_s(r_sync2),
    .level (r_level),
    .audio (audio)
  );

  assign level = r_level;
  assign busy  = r_busy;

endmodule

// File: tb/tb_audio_envelope.sv
// Bench for audio_envelope with default parameters. Expectations follow
// the build option AUDIO_ENV_SUSTAIN_EN the same way the design does.
module tb_audio_envelope;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tone_in = 1'b1;
  logic       gate = 1'b1;
  logic       tick = 1'b0;
  logic       audio;
  logic [5:0] level;
  logic       busy;

  always #5 clk = ~clk;

  audio_envelope dut (
    .clk    (clk),
    .rst    (rst),
    .tone_in(tone_in),
    .gate   (gate),
    .tick   (tick),
    .audio  (audio),
    .level  (level),
    .busy   (busy)
  );

  typedef struct {
    logic       gate;
    logic       tick;
    logic [5:0] lvl;
    logic       busy;
  } vec_t;

  typedef struct {
    logic [5:0] lvl;
    logic       busy;
    string      tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected registered result,
  // then compare once the edge has produced it.
  task automatic step(input logic g, input logic t, input logic [5:0] el,
                      input logic eb, input string tag);
    exp_t e;
    gate = g;
    tick = t;
    e.lvl  = el;
    e.busy = eb;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " level"}, 32'(level), 32'(e.lvl));
      chk({e.tag, " busy"}, 32'(busy), 32'(e.busy));
    end
  endtask

  // Hold inputs for n cycles and count cycles with audio high.
  task automatic count_audio(input logic g, input logic [5:0] el, input logic eb,
                             input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step(g, 1'b0, el, eb, "duty");
      if (audio === 1'b1) hi++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    int hi;

    // Reset held with gate high and tick toggling.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, i[0], 6'd0, 1'b0, "reset");
      chk("reset audio", 32'(audio), 32'd0);
    end
    rst = 1'b0;
    step(1'b0, 1'b1, 6'd0, 1'b0, "post reset");
    chk("post reset audio", 32'(audio), 32'd0);

    // PWM duty at level 0, 24, 0-tone and MAX.
    count_audio(1'b0, 6'd0, 1'b0, 64, hi);
    chk("duty level0", 32'(hi), 32'd0);
    step(1'b1, 1'b0, 6'd0, 1'b1, "duty gate");
    step(1'b1, 1'b1, 6'd8, 1'b1, "duty att1");
    step(1'b1, 1'b1, 6'd16, 1'b1, "duty att2");
    step(1'b1, 1'b1, 6'd24, 1'b1, "duty att3");
    step(1'b1, 1'b0, 6'd24, 1'b1, "duty settle");
    count_audio(1'b1, 6'd24, 1'b1, 64, hi);
    chk("duty level24", 32'(hi), 32'd24);
    tone_in = 1'b0;
    repeat (3) step(1'b1, 1'b0, 6'd24, 1'b1, "tone off settle");
    count_audio(1'b1, 6'd24, 1'b1, 64, hi);
    chk("duty tone0", 32'(hi), 32'd0);
    tone_in = 1'b1;
    repeat (3) step(1'b1, 1'b0, 6'd24, 1'b1, "tone on settle");
    step(1'b1, 1'b1, 6'd32, 1'b1, "duty att4");
    step(1'b1, 1'b1, 6'd40, 1'b1, "duty att5");
    step(1'b1, 1'b1, 6'd48, 1'b1, "duty att6");
    step(1'b1, 1'b1, 6'd56, 1'b1, "duty att7");
    step(1'b1, 1'b1, 6'd63, 1'b1, "duty att8");
    step(1'b1, 1'b0, 6'd63, 1'b1, "duty settle max");
    count_audio(1'b1, 6'd63, 1'b1, 64, hi);
    chk("duty level63", 32'(hi), 32'd63);

    // Reset mid-envelope overrides a simultaneous tick.
    rst = 1'b1;
    step(1'b1, 1'b1, 6'd0, 1'b0, "mid reset");
    chk("mid reset audio", 32'(audio), 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b1, 6'd0, 1'b0, "after mid reset");

    // Attack/decay table, tick every 4th cycle.
    vecs.push_back('{1'b1, 1'b0, 6'd0, 1'b1});
    for (int k = 1; k <= 8; k++) begin
      int p;
      int n;
      p = (8 * (k - 1) > 63) ? 63 : 8 * (k - 1);
      n = (8 * k > 63) ? 63 : 8 * k;
      repeat (3) vecs.push_back('{1'b1, 1'b0, 6'(p), 1'b1});
      vecs.push_back('{1'b1, 1'b1, 6'(n), 1'b1});
    end
`ifdef AUDIO_ENV_SUSTAIN_EN
    for (int j = 1; j <= 39; j++) begin
      repeat (3) vecs.push_back('{1'b1, 1'b0, 6'(64 - j), 1'b1});
      vecs.push_back('{1'b1, 1'b1, 6'(63 - j), 1'b1});
    end
    repeat (4) vecs.push_back('{1'b1, 1'b1, 6'd24, 1'b1});
`else
    for (int j = 1; j <= 63; j++) begin
      repeat (3) vecs.push_back('{1'b1, 1'b0, 6'(64 - j), 1'b1});
      vecs.push_back('{1'b1, 1'b1, 6'(63 - j), (j != 63)});
    end
    repeat (4) vecs.push_back('{1'b1, 1'b1, 6'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 6'd0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 6'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 6'd8, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 6'd8, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 6'd6, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 6'd4, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 6'd2, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 6'd0, 1'b0});
`endif
    foreach (vecs[i]) begin
      step(vecs[i].gate, vecs[i].tick, vecs[i].lvl, vecs[i].busy,
           $sformatf("vec%0d", i));
    end

    // Gate drop on a tick cycle: release starts, level not stepped.
`ifndef AUDIO_ENV_SUSTAIN_EN
    step(1'b1, 1'b0, 6'd0, 1'b1, "rel gate");
    step(1'b1, 1'b1, 6'd8, 1'b1, "rel att1");
    step(1'b1, 1'b1, 6'd16, 1'b1, "rel att2");
    step(1'b1, 1'b1, 6'd24, 1'b1, "rel att3");
`endif
    step(1'b0, 1'b1, 6'd24, 1'b1, "collision");
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1, 6'(24 - 2 * i), (i != 12), $sformatf("release%0d", i));
    end
    step(1'b0, 1'b1, 6'd0, 1'b0, "idle hold");

    // Retrigger from the middle of a release keeps the current level.
    step(1'b1, 1'b0, 6'd0, 1'b1, "rt gate");
    step(1'b1, 1'b1, 6'd8, 1'b1, "rt att1");
    step(1'b1, 1'b1, 6'd16, 1'b1, "rt att2");
    step(1'b1, 1'b1, 6'd24, 1'b1, "rt att3");
    step(1'b0, 1'b1, 6'd24, 1'b1, "rt drop");
    for (int i = 1; i <= 7; i++) begin
      step(1'b0, 1'b1, 6'(24 - 2 * i), 1'b1, $sformatf("rt release%0d", i));
    end
    step(1'b1, 1'b1, 6'd10, 1'b1, "retrigger");
    step(1'b1, 1'b0, 6'd10, 1'b1, "retrigger hold");
    step(1'b1, 1'b1, 6'd18, 1'b1, "retrigger tick");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
